// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the RV32M multiply/divide sequencer.
//   mdu_op_t    - funct3 encodings of the eight M-extension ops
//   mdu_state_t - sequencer states
//   XLEN_DEFAULT, M_FUNCT7 - width default and the funct7 that selects the MDU
//   is_signed_a/is_signed_b - operand signedness per op
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_t;

  function automatic logic is_signed_a(mdu_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(mdu_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/response bundle between the control path and the MDU.
//   master: start, funct3, op_a, op_b out; busy, done, stall, result in
//   slave : the sequencer side (mirror of master)
interface mdu_seq_if #(
  parameter int XLEN = mdu_pkg::XLEN_DEFAULT
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic            stall;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b,
                  input  busy, done, stall, result);
  modport slave  (input  start, funct3, op_a, op_b,
                  output busy, done, stall, result);
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the MDU loop.
//   is_div=0: shift-add; acc += mcand if mplier[0], mcand <<= 1, mplier >>= 1.
//             The product is complete whenever the remaining multiplier is 0.
//   is_div=1: restoring step on acc = {remainder, quotient/dividend};
//             mplier holds the divisor, mcand passes through.
//   Ports: is_div, acc_i/acc_o (2*XLEN), mcand_i/mcand_o (2*XLEN),
//          mplier_i/mplier_o (XLEN).
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [2*XLEN-1:0] mcand_i,
  input  logic [XLEN-1:0]   mplier_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [2*XLEN-1:0] mcand_o,
  output logic [XLEN-1:0]   mplier_o
);

  logic [XLEN:0] hi;
  logic [XLEN:0] diff;

  always_comb begin
    acc_o    = acc_i;
    mcand_o  = mcand_i;
    mplier_o = mplier_i;
    // Partial remainder shifted left with the next dividend bit brought in.
    hi   = acc_i[2*XLEN-1:XLEN-1];
    diff = hi - {1'b0, mplier_i};
    if (is_div) begin
      // Borrow out of the trial subtract means restore (quotient bit 0).
      if (!diff[XLEN]) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else             acc_o = {hi[XLEN-1:0],   acc_i[XLEN-2:0], 1'b0};
    end else begin
      if (mplier_i[0]) acc_o = acc_i + mcand_i;
      mcand_o  = {mcand_i[2*XLEN-2:0], 1'b0};
      mplier_o = {1'b0, mplier_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer.
//   IDLE -> PREP (magnitudes, signs, special cases) -> CALC (XLEN steps)
//   -> FIX (sign correction, word select) -> DONE (one-cycle done pulse).
//   Divide-by-zero and signed overflow go PREP -> DONE directly.
//   Ports: clk, rst_n (synchronous, active-low), bus (mdu_seq_if.slave):
//     start/funct3/op_a/op_b in; busy/done/stall/result out.
//   stall = (start & IDLE) | busy, so the core holds until the done cycle.
//   Optional MDU_EARLY_OUT_EN: multiplies leave CALC as soon as the
//   remaining multiplier magnitude is zero; division is unaffected.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mdu_seq_if.slave bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        state_q, state_d;
  mdu_op_t           op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, busy;
  logic [XLEN-1:0]   mag_a, mag_b, quo, rem, quo_s, rem_s;
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] step_acc, step_mcand;
  logic [XLEN-1:0]   step_mplier;

  assign is_div = op_q[2];

  assign mag_a = (is_signed_a(op_q) && a_q[XLEN-1]) ? (~a_q) + XLEN'(1) : a_q;
  assign mag_b = (is_signed_b(op_q) && b_q[XLEN-1]) ? (~b_q) + XLEN'(1) : b_q;

  // Divide layout is {remainder, quotient}; sign fixes use the recorded flags.
  assign quo    = acc_q[XLEN-1:0];
  assign rem    = acc_q[2*XLEN-1:XLEN];
  assign quo_s  = (neg_a_q ^ neg_b_q) ? (~quo) + XLEN'(1) : quo;
  assign rem_s  = neg_a_q ? (~rem) + XLEN'(1) : rem;
  assign prod_s = (neg_a_q ^ neg_b_q) ? (~acc_q) + (2*XLEN)'(1) : acc_q;

  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div   (is_div),
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (step_acc),
    .mcand_o  (step_mcand),
    .mplier_o (step_mplier)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = mdu_op_t'(bus.funct3);
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_a_d  = is_signed_a(op_q) & a_q[XLEN-1];
        neg_b_d  = is_signed_b(op_q) & b_q[XLEN-1];
        cnt_d    = CNT_W'(XLEN);
        mplier_d = mag_b;
        if (is_div) begin
          acc_d   = {{XLEN{1'b0}}, mag_a};
          mcand_d = '0;
        end else begin
          acc_d   = '0;
          mcand_d = {{XLEN{1'b0}}, mag_a};
        end
        state_d = S_CALC;
        // op_q[1] distinguishes REM/REMU from DIV/DIVU.
        if (is_div && (b_q == '0)) begin
          result_d = op_q[1] ? a_q : '1;
          state_d  = S_DONE;
        end else if (is_div && is_signed_a(op_q) && (a_q == MIN_NEG) && (b_q == '1)) begin
          result_d = op_q[1] ? '0 : MIN_NEG;
          state_d  = S_DONE;
        end
`ifdef MDU_EARLY_OUT_EN
        else if (!is_div && (mag_b == '0)) begin
          state_d = S_FIX;
        end
`endif
      end
      S_CALC: begin
        acc_d    = step_acc;
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
`ifdef MDU_EARLY_OUT_EN
        // Nothing left to add: the accumulated product is already final.
        if (!is_div && (step_mplier == '0)) state_d = S_FIX;
`endif
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_div)              result_d = op_q[1] ? rem_s : quo_s;
        else if (op_q == OP_MUL) result_d = prod_s[XLEN-1:0];
        else                     result_d = prod_s[2*XLEN-1:XLEN];
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      result_q <= result_d;
    end
  end

  assign busy       = state_q inside {S_PREP, S_CALC, S_FIX};
  assign bus.busy   = busy;
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.stall  = (bus.start & (state_q == S_IDLE)) | busy;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  mdu_seq_if #(.XLEN(32)) bus ();

  mdu_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit / native SV arithmetic on the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    int si, sj;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    si = a;
    sj = b;
    case (f)
      3'd0: begin pu = ua * ub; return pu[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
        return si / sj;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
        return si % sj;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] m;
`endif
    if (f[2] && (b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF))) return 2;
`ifdef MDU_EARLY_OUT_EN
    if (!f[2]) begin
      m = (f == 3'd1 && b[31]) ? 32'd0 - b : b;
      if (m == 0) return 3;
      for (int i = 31; i >= 0; i--) if (m[i]) return 4 + i;
    end
`endif
    return 35;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Drives one op (cycle 0 = start accepted), scrambles inputs and start
  // afterwards, and reports result, done cycle and any stall violation.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit stall_bad);
    stall_bad = 1'b0;
    lat = -1;
    res = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
    #1;
    if (bus.stall !== 1'b1) stall_bad = 1'b1;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
      bus.funct3 = 3'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
      #1;
      if (bus.done === 1'b1) begin
        lat = c;
        res = bus.result;
        if (bus.stall !== 1'b0) stall_bad = 1'b1;
      end else if (bus.stall !== 1'b1) stall_bad = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.op_a = 32'd0; bus.op_b = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  f  [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4};
    logic [31:0] va [11] = '{32'd7, MIN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd10, 32'd10, MIN};
    logic [31:0] vb [11] = '{32'hFFFF_FFFD, MIN, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ve [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                             32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd10, MIN};
    logic [31:0] res;
    int lat;
    bit sbad;
    for (int i = 0; i < 11; i++) begin
      run_op(f[i], va[i], vb[i], res, lat, sbad);
      checks++; if (res !== ve[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, ve[i]); end
      checks++; if (lat != exp_lat(f[i], va[i], vb[i])) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_lat(f[i], va[i], vb[i])); end
      checks++; if (sbad) begin errors++; $display("FAIL dir%0d_stall got violation want stall high until done", i); end
    end
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [31:0] a, b, res;
    int lat;
    bit sbad;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = rand_opnd();
      b = rand_opnd();
      run_op(f, a, b, res, lat, sbad);
      checks++; if (res !== model(f, a, b)) begin errors++; $display("FAIL rnd%0d_result op %0d a %h b %h got %h want %h", i, f, a, b, res, model(f, a, b)); end
      checks++; if (lat != exp_lat(f, a, b) || sbad) begin errors++; $display("FAIL rnd%0d_timing op %0d got lat %0d stall_bad %0d want lat %0d", i, f, lat, sbad, exp_lat(f, a, b)); end
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    logic [31:0] res;
    int lat;
    bit sbad;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'h1234_5678; bus.op_b = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
    end
    rst_n = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL rstmid_result got %h want 0", bus.result); end
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rstmid_no_done got done pulse want none"); end
    run_op(3'd5, 32'd9, 32'd3, res, lat, sbad);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL rstmid_divu_result got %h want 3", res); end
    checks++; if (lat != 35) begin errors++; $display("FAIL rstmid_divu_latency got %0d want 35", lat); end
  endtask

  task automatic test_early_out();
    logic [31:0] res, x;
    int lat;
    bit sbad;
    int want_a, want_b;
`ifdef MDU_EARLY_OUT_EN
    want_a = 6; want_b = 3;
`else
    want_a = 35; want_b = 35;
`endif
    run_op(3'd0, 32'd3, 32'd5, res, lat, sbad);
    checks++; if (res !== 32'd15) begin errors++; $display("FAIL early_mul35_result got %h want 15", res); end
    checks++; if (lat != want_a) begin errors++; $display("FAIL early_mul35_latency got %0d want %0d", lat, want_a); end
    x = $urandom | 32'h1;
    run_op(3'd0, x, 32'd0, res, lat, sbad);
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL early_mul0_result got %h want 0", res); end
    checks++; if (lat != want_b) begin errors++; $display("FAIL early_mul0_latency got %0d want %0d", lat, want_b); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_early_out();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
